// File: rtl/xm23_pkg.sv
// Shared definitions for the XM23 priority interrupt controller:
// device CSR bit positions, pic_in request word layout, PIC FSM encoding.
package xm23_pkg;

  // Device CSR bit positions
  localparam int unsigned CSR_IE     = 0;
  localparam int unsigned CSR_DBA    = 2;
  localparam int unsigned CSR_PRI_LO = 5;
  localparam int unsigned CSR_PRI_HI = 7;

  localparam int unsigned CSR_W  = 8;
  localparam int unsigned PRI_W  = CSR_PRI_HI - CSR_PRI_LO + 1;
  localparam int unsigned VECT_W = 4;
  localparam int unsigned PIC_W  = 1 + PRI_W + VECT_W;

  // pic_in request word: {req, pri[2:0], vect[3:0]}
  typedef struct packed {
    logic              req;
    logic [PRI_W-1:0]  pri;
    logic [VECT_W-1:0] vect;
  } pic_in_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } pic_state_e;

endpackage

// File: rtl/pic_arbiter.sv
// Combinational priority arbiter.
//   elig_i    : per-device eligible flags
//   pri_i     : packed per-device priorities, device i at [PRI_W*i +: PRI_W]
//   win_idx_o : index of the winning device
//   win_pri_o : priority of the winning device
//   valid_o   : at least one device is eligible
// Highest priority wins; ties go to the lowest index.
module pic_arbiter
  import xm23_pkg::*;
#(
  parameter int unsigned N_DEV = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N_DEV-1:0]       elig_i,
  input  logic [PRI_W*N_DEV-1:0] pri_i,
  output logic [IDX_W-1:0]       win_idx_o,
  output logic [PRI_W-1:0]       win_pri_o,
  output logic                   valid_o
);

  logic             found;
  logic [IDX_W-1:0] best_idx;
  logic [PRI_W-1:0] best_pri;

  // Scan from the top index down using >=, so a lower index displaces an equal priority
  always_comb begin
    found    = 1'b0;
    best_idx = '0;
    best_pri = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (elig_i[i] && (!found || (pri_i[PRI_W*i +: PRI_W] >= best_pri))) begin
        found    = 1'b1;
        best_idx = IDX_W'(i);
        best_pri = pri_i[PRI_W*i +: PRI_W];
      end
    end
  end

  assign win_idx_o = best_idx;
  assign win_pri_o = best_pri;
  assign valid_o   = found;

endmodule

// File: rtl/xm23_pic.sv
// XM23 priority interrupt controller.
//   Clock, Reset_n : clock and async active-low reset
//   dev_csr        : live device CSR bytes, device i at [8*i +: 8]
//   cur_pri        : CPU current priority (PSW[7:5])
//   pic_read       : one-cycle acknowledge from the control unit
//   ovr_clr        : per-device overrun clear
//   pic_in         : registered request word {req, pri, vect}
//   irq_pending    : per-device pending latch
//   irq_ovr        : sticky per-device overrun flag
module xm23_pic
  import xm23_pkg::*;
#(
  parameter int unsigned N_DEV     = 5,
  parameter int unsigned VECT_BASE = 8
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [CSR_W*N_DEV-1:0] dev_csr,
  input  logic [PRI_W-1:0]       cur_pri,
  input  logic                   pic_read,
  input  logic [N_DEV-1:0]       ovr_clr,
  output logic [PIC_W-1:0]       pic_in,
  output logic [N_DEV-1:0]       irq_pending,
  output logic [N_DEV-1:0]       irq_ovr
);

  localparam int unsigned IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  pic_state_e state_q, state_d;
  pic_in_t    pic_q, pic_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [N_DEV-1:0] prev_q, pending_q, pending_d, ovr_q, ovr_d;

  logic [N_DEV-1:0]       ie, dba, elig, ev, grant_oh, ack_clr;
  logic [PRI_W*N_DEV-1:0] pri_vec;
  logic [3*N_DEV-1:0]     csr_unused_bits;
  logic                   csr_unused;
  logic [IDX_W-1:0]       win_idx;
  logic [PRI_W-1:0]       win_pri;
  logic                   win_valid, ack;

  // CSR field extraction and per-device eligibility
  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      ie[i]                     = dev_csr[CSR_W*i + CSR_IE];
      dba[i]                    = dev_csr[CSR_W*i + CSR_DBA];
      pri_vec[PRI_W*i +: PRI_W] = dev_csr[CSR_W*i + CSR_PRI_LO +: PRI_W];
      elig[i]                   = pending_q[i] & ie[i] &
                                  (dev_csr[CSR_W*i + CSR_PRI_LO +: PRI_W] > cur_pri);
      csr_unused_bits[3*i +: 3] = {dev_csr[CSR_W*i + 4], dev_csr[CSR_W*i + 3],
                                   dev_csr[CSR_W*i + 1]};
    end
  end
  assign csr_unused = ^csr_unused_bits;

  pic_arbiter #(
    .N_DEV (N_DEV),
    .IDX_W (IDX_W)
  ) u_arb (
    .elig_i    (elig),
    .pri_i     (pri_vec),
    .win_idx_o (win_idx),
    .win_pri_o (win_pri),
    .valid_o   (win_valid)
  );

  // Rising edge of IE&DBA is the interrupt event
  assign ev       = ie & dba & ~prev_q;
  assign grant_oh = N_DEV'(1) << grant_q;
  assign ack_clr  = ack ? grant_oh : '0;

  // Set wins over clear for both pending and overrun
  assign pending_d = (pending_q & ~ack_clr) | ev;
  assign ovr_d     = (ovr_q & ~ovr_clr) | (ev & pending_q);

  // Next-state and request-word logic
  always_comb begin
    state_d = state_q;
    pic_d   = pic_q;
    grant_d = grant_q;
    ack     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pic_d = '0;
        if (win_valid) begin
          pic_d.req  = 1'b1;
          pic_d.pri  = win_pri;
          pic_d.vect = VECT_W'(VECT_BASE) + VECT_W'(win_idx);
          grant_d    = win_idx;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack takes precedence over revocation; no preemption while held
        if (pic_read) begin
          ack     = 1'b1;
          pic_d   = '0;
          state_d = ST_GAP;
        end else if (~|(elig & grant_oh)) begin
          pic_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        pic_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        pic_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      pic_q     <= '0;
      grant_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pic_q     <= pic_d;
      grant_q   <= grant_d;
      prev_q    <= ie & dba;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pic_in      = pic_q;
  assign irq_pending = pending_q;
  assign irq_ovr     = ovr_q;

endmodule

// File: tb/tb_xm23_pic.sv
// Directed self-checking bench for xm23_pic.
module tb_xm23_pic;

  localparam int unsigned N_DEV = 5;

  logic             Clock;
  logic             Reset_n;
  logic [8*N_DEV-1:0] dev_csr;
  logic [2:0]       cur_pri;
  logic             pic_read;
  logic [N_DEV-1:0] ovr_clr;
  logic [7:0]       pic_in;
  logic [N_DEV-1:0] irq_pending;
  logic [N_DEV-1:0] irq_ovr;

  int checks   = 0;
  int failures = 0;

  xm23_pic #(.N_DEV(N_DEV), .VECT_BASE(8)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .dev_csr     (dev_csr),
    .cur_pri     (cur_pri),
    .pic_read    (pic_read),
    .ovr_clr     (ovr_clr),
    .pic_in      (pic_in),
    .irq_pending (irq_pending),
    .irq_ovr     (irq_ovr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one rising edge; inputs driven and outputs sampled 1ns later
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_dev(input int i, input logic [7:0] v);
    dev_csr[8*i +: 8] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    dev_csr  = '0;
    cur_pri  = 3'd3;
    pic_read = 1'b0;
    ovr_clr  = '0;
    set_dev(0, 8'hA5);

    // Reset with an already-active timer CSR
    step(); step();
    chk("rst_pic_in", 32'(pic_in), 32'h00);
    chk("rst_pending", 32'(irq_pending), 32'h00);
    chk("rst_ovr", 32'(irq_ovr), 32'h00);
    Reset_n = 1'b1;
    step();
    chk("rel_pending", 32'(irq_pending), 32'h01);
    chk("rel_pic_early", 32'(pic_in), 32'h00);
    step();
    chk("rel_pic_req", 32'(pic_in), 32'hD8);
    pic_read = 1'b1;
    step();
    pic_read = 1'b0;
    set_dev(0, 8'hA1);
    chk("ack0_pic", 32'(pic_in), 32'h00);
    chk("ack0_pending", 32'(irq_pending), 32'h00);
    step(); step();
    chk("idle0_pic", 32'(pic_in), 32'h00);

    // Tie between devices 1 and 3 at pri 4
    cur_pri = 3'd0;
    set_dev(1, 8'h85);
    set_dev(3, 8'h85);
    step();
    chk("tie_pending", 32'(irq_pending), 32'h0A);
    step();
    chk("tie_grant", 32'(pic_in), 32'hC9);
    pic_read = 1'b1;
    step();
    pic_read = 1'b0;
    chk("tie_ack_pic", 32'(pic_in), 32'h00);
    chk("tie_ack_pending", 32'(irq_pending), 32'h08);
    step();
    chk("tie_gap_pic", 32'(pic_in), 32'h00);
    step();
    chk("tie_second", 32'(pic_in), 32'hCB);
    pic_read = 1'b1;
    step();
    pic_read = 1'b0;
    set_dev(1, 8'h81);
    set_dev(3, 8'h81);
    step(); step();

    // No preemption by a higher-priority arrival
    set_dev(0, 8'h45);
    step();
    chk("np_pending", 32'(irq_pending), 32'h01);
    step();
    chk("np_grant", 32'(pic_in), 32'hA8);
    set_dev(4, 8'hC5);
    step();
    chk("np_pending2", 32'(irq_pending), 32'h11);
    chk("np_hold1", 32'(pic_in), 32'hA8);
    step();
    chk("np_hold2", 32'(pic_in), 32'hA8);
    pic_read = 1'b1;
    step();
    pic_read = 1'b0;
    chk("np_ack_pic", 32'(pic_in), 32'h00);
    chk("np_ack_pending", 32'(irq_pending), 32'h10);
    step();
    chk("np_gap_pic", 32'(pic_in), 32'h00);
    step();
    chk("np_next", 32'(pic_in), 32'hEC);
    pic_read = 1'b1;
    step();
    pic_read = 1'b0;
    step(); step();
    chk("np_ovr", 32'(irq_ovr), 32'h00);

    // Revocation by raising cur_pri, then reissue
    set_dev(0, 8'h41);
    step();
    set_dev(0, 8'h45);
    step();
    step();
    chk("rv_grant", 32'(pic_in), 32'hA8);
    cur_pri = 3'd2;
    step();
    chk("rv_drop", 32'(pic_in), 32'h00);
    chk("rv_pending", 32'(irq_pending), 32'h01);
    step();
    chk("rv_idle", 32'(pic_in), 32'h00);
    cur_pri = 3'd1;
    step();
    chk("rv_reissue", 32'(pic_in), 32'hA8);
    pic_read = 1'b1;
    step();
    pic_read = 1'b0;
    chk("rv_ack_pending", 32'(irq_pending), 32'h00);
    step(); step();

    // Overrun on device 2 (kept ineligible by cur_pri=7)
    cur_pri = 3'd7;
    set_dev(2, 8'h65);
    step();
    chk("ov_pending", 32'(irq_pending), 32'h04);
    set_dev(2, 8'h61);
    step();
    set_dev(2, 8'h65);
    step();
    chk("ov_set", 32'(irq_ovr), 32'h04);
    set_dev(2, 8'h61);
    step();
    set_dev(2, 8'h65);
    ovr_clr = 5'b00100;
    step();
    chk("ov_set_wins", 32'(irq_ovr), 32'h04);
    step();
    ovr_clr = '0;
    chk("ov_clear", 32'(irq_ovr), 32'h00);

    // pic_read in IDLE is ignored; IE=0 produces no event
    pic_read = 1'b1;
    step();
    pic_read = 1'b0;
    chk("idle_read_pic", 32'(pic_in), 32'h00);
    chk("idle_read_pending", 32'(irq_pending), 32'h04);
    set_dev(3, 8'h84);
    step();
    chk("ie0_pending", 32'(irq_pending), 32'h04);
    step();
    chk("ie0_pic", 32'(pic_in), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
